// File: rtl/fdiv_seq_ctrl.sv
// fdiv_seq_ctrl: multi-cycle IEEE-754 single divide sequencer; define FDIV_RNE_EN for round-to-nearest-even (default truncation)
module fdiv_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        flag_nv,
  output logic        flag_dz,
  output logic        flag_of,
  output logic        flag_uf,
  output logic        flag_nx
);
  localparam int ITERS = 26;
  localparam int BIAS = 127;
  typedef enum logic [2:0] {IDLE, CHECK, ITER, NORM, PACK} state_t;
  state_t state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic sign_q, sign_d, done_q, done_d, g_q, g_d, s_q, s_d;
  logic [25:0] r_q, r_d, q_q, q_d;
  logic [23:0] d_q, d_d;
  logic [22:0] mant_q, mant_d;
  logic [4:0] cnt_q, cnt_d, flg_q, flg_d;
  logic signed [9:0] e_q, e_d;
  logic [7:0] ea, eb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn, ge;
  logic [25:0] diff;
  logic signed [9:0] e_fin;
  logic [22:0] frac_fin;
  logic [31:0] ovf_res;
  assign ea = a_q[30:23];
  assign eb = b_q[30:23];
  assign a_zero = ea == 8'd0;
  assign b_zero = eb == 8'd0;
  assign a_inf = ea == 8'hFF && a_q[22:0] == 23'd0;
  assign b_inf = eb == 8'hFF && b_q[22:0] == 23'd0;
  assign a_nan = ea == 8'hFF && a_q[22:0] != 23'd0;
  assign b_nan = eb == 8'hFF && b_q[22:0] != 23'd0;
  assign sgn = a_q[31] ^ b_q[31];
  assign ge = r_q >= {2'b00, d_q};
  assign diff = r_q - {2'b00, d_q};
`ifdef FDIV_RNE_EN
  logic [24:0] rnd;
  assign rnd = {2'b01, mant_q} + {24'd0, g_q & (s_q | mant_q[0])};
  assign e_fin = rnd[24] ? e_q + 10'sd1 : e_q;
  assign frac_fin = rnd[24] ? rnd[23:1] : rnd[22:0];
  assign ovf_res = {sign_q, 8'hFF, 23'd0};
`else
  assign e_fin = e_q;
  assign frac_fin = mant_q;
  assign ovf_res = {sign_q, 8'hFE, 23'h7FFFFF};
`endif
  assign busy = state_q inside {ITER, NORM, PACK};
  assign done = done_q;
  assign result = res_q;
  assign {flag_nv, flag_dz, flag_of, flag_uf, flag_nx} = flg_q;
  // Next-state and datapath: screening, restoring divide, normalize, round and pack
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sign_d = sign_q;
    r_d = r_q;
    d_d = d_q;
    q_d = q_q;
    cnt_d = cnt_q;
    e_d = e_q;
    mant_d = mant_q;
    g_d = g_q;
    s_d = s_q;
    res_d = res_q;
    flg_d = flg_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        a_d = op_a;
        b_d = op_b;
        flg_d = '0;
        state_d = CHECK;
      end
      CHECK: begin
        sign_d = sgn;
        state_d = IDLE;
        done_d = 1'b1;
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
          res_d = 32'h7FC00000;
          flg_d = 5'b10000;
        end else if (a_inf) res_d = {sgn, 8'hFF, 23'd0};
        else if (b_zero) begin
          res_d = {sgn, 8'hFF, 23'd0};
          flg_d = 5'b01000;
        end else if (a_zero | b_inf) res_d = {sgn, 31'd0};
        else begin
          done_d = 1'b0;
          r_d = {3'b001, a_q[22:0]};
          d_d = {1'b1, b_q[22:0]};
          q_d = '0;
          cnt_d = '0;
          e_d = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'(BIAS);
          state_d = ITER;
        end
      end
      ITER: begin
        r_d = ge ? {diff[24:0], 1'b0} : {r_q[24:0], 1'b0};
        q_d = {q_q[24:0], ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITERS - 1)) state_d = NORM;
      end
      NORM: begin
        mant_d = q_q[25] ? q_q[24:2] : q_q[23:1];
        g_d = q_q[25] ? q_q[1] : q_q[0];
        s_d = (q_q[25] & q_q[0]) | (r_q != 26'd0);
        e_d = q_q[25] ? e_q : e_q - 10'sd1;
        state_d = PACK;
      end
      PACK: begin
        done_d = 1'b1;
        state_d = IDLE;
        res_d = e_fin >= 10'sd255 ? ovf_res : e_fin <= 10'sd0 ? {sign_q, 31'd0} : {sign_q, e_fin[7:0], frac_fin};
        flg_d = e_fin >= 10'sd255 ? 5'b00101 : e_fin <= 10'sd0 ? 5'b00011 : {4'b0000, g_q | s_q};
      end
      default: state_d = IDLE;
    endcase
    if (flush && state_q != IDLE) begin
      state_d = IDLE;
      done_d = 1'b0;
      res_d = res_q;
      flg_d = flg_q;
    end
  end
  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sign_q <= 1'b0;
      r_q <= '0;
      d_q <= '0;
      q_q <= '0;
      cnt_q <= '0;
      e_q <= '0;
      mant_q <= '0;
      g_q <= 1'b0;
      s_q <= 1'b0;
      res_q <= '0;
      flg_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sign_q <= sign_d;
      r_q <= r_d;
      d_q <= d_d;
      q_q <= q_d;
      cnt_q <= cnt_d;
      e_q <= e_d;
      mant_q <= mant_d;
      g_q <= g_d;
      s_q <= s_d;
      res_q <= res_d;
      flg_q <= flg_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_fdiv_seq_ctrl.sv
// tb_fdiv_seq_ctrl: directed self-checking bench for the divide sequencer
module tb_fdiv_seq_ctrl;
  logic clk, rst, start, flush;
  logic [31:0] op_a, op_b, result;
  logic busy, done, flag_nv, flag_dz, flag_of, flag_uf, flag_nx;
  logic [4:0] flg;
  int cmp, err;
  assign flg = {flag_nv, flag_dz, flag_of, flag_uf, flag_nx};
  fdiv_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .flag_nv(flag_nv), .flag_dz(flag_dz),
    .flag_of(flag_of), .flag_uf(flag_uf), .flag_nx(flag_nx)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
`ifdef FDIV_RNE_EN
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
  localparam logic [31:0] OVF = 32'h7F800000;
`else
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
  localparam logic [31:0] OVF = 32'h7F7FFFFF;
`endif
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) bcnt++;
    end
  endtask
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res, output logic [4:0] f, output int lat, output int bcnt);
    @(negedge clk);
    op_a = a;
    op_b = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bcnt);
    res = result;
    f = flg;
  endtask
  task automatic test_reset;
    cmp++;
    if ({busy, done, result, flg} !== 39'd0) begin
      err++;
      $display("FAIL reset: busy=%b done=%b result=%h flags=%b, want all zero", busy, done, result, flg);
    end
  endtask
  task automatic test_divide;
    logic [31:0] r;
    logic [4:0] f;
    int lat, bc;
    do_op(32'h40C00000, 32'h40000000, r, f, lat, bc);
    cmp++; if (r !== 32'h40400000) begin err++; $display("FAIL div6_2 result: got %h want 40400000", r); end
    cmp++; if (f !== 5'b00000) begin err++; $display("FAIL div6_2 flags: got %b want 00000", f); end
    cmp++; if (lat !== 29) begin err++; $display("FAIL div6_2 latency: got %0d want 29", lat); end
    cmp++; if (bc !== 28) begin err++; $display("FAIL div6_2 busy cycles: got %0d want 28", bc); end
    @(posedge clk);
    #1;
    cmp++; if (done !== 1'b0 || busy !== 1'b0) begin err++; $display("FAIL div6_2 done pulse: done=%b busy=%b want 0 0", done, busy); end
    do_op(32'h3F800000, 32'h40400000, r, f, lat, bc);
    cmp++; if (r !== THIRD) begin err++; $display("FAIL div1_3 result: got %h want %h", r, THIRD); end
    cmp++; if (f !== 5'b00001) begin err++; $display("FAIL div1_3 flags: got %b want 00001", f); end
  endtask
  task automatic test_special;
    logic [31:0] va [3] = '{32'hBF800000, 32'h00000000, 32'h7FC00001};
    logic [31:0] vb [3] = '{32'h00000000, 32'h00000000, 32'h3F800000};
    logic [31:0] vr [3] = '{32'hFF800000, 32'h7FC00000, 32'h7FC00000};
    logic [4:0] vf [3] = '{5'b01000, 5'b10000, 5'b10000};
    logic [31:0] r;
    logic [4:0] f;
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], r, f, lat, bc);
      cmp++; if (r !== vr[i] || f !== vf[i]) begin err++; $display("FAIL special%0d: got %h/%b want %h/%b", i, r, f, vr[i], vf[i]); end
      cmp++; if (lat !== 1 || bc !== 0) begin err++; $display("FAIL special%0d latency: got %0d busy %0d want 1 0", i, lat, bc); end
    end
  endtask
  task automatic test_range;
    logic [31:0] r;
    logic [4:0] f;
    int lat, bc;
    do_op(32'h7F000000, 32'h3E800000, r, f, lat, bc);
    cmp++; if (r !== OVF || f !== 5'b00101) begin err++; $display("FAIL overflow: got %h/%b want %h/00101", r, f, OVF); end
    do_op(32'h00800000, 32'h7F000000, r, f, lat, bc);
    cmp++; if (r !== 32'h0 || f !== 5'b00011) begin err++; $display("FAIL underflow: got %h/%b want 00000000/00011", r, f); end
  endtask
  task automatic test_flush;
    logic [31:0] r;
    logic [4:0] f;
    int lat, bc;
    logic seen;
    do_op(32'h40C00000, 32'h40000000, r, f, lat, bc);
    @(negedge clk);
    op_a = 32'h3F800000;
    op_b = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    cmp++; if (busy !== 1'b0 || done !== 1'b0) begin err++; $display("FAIL flush stop: busy=%b done=%b want 0 0", busy, done); end
    seen = 1'b0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    cmp++; if (seen !== 1'b0) begin err++; $display("FAIL flush no done: saw done=%b want 0", seen); end
    cmp++; if (result !== 32'h40400000) begin err++; $display("FAIL flush result: got %h want 40400000", result); end
  endtask
  task automatic test_busy_start;
    int lat, bc;
    @(negedge clk);
    op_a = 32'h40C00000;
    op_b = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1 op_a = 32'h3F800000;
    op_b = 32'h40400000;
    repeat (10) @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bc);
    lat += 10;
    cmp++; if (result !== 32'h40400000 || lat !== 29) begin err++; $display("FAIL busy start: got %h lat %0d want 40400000 lat 29", result, lat); end
    @(posedge clk);
    #1;
    cmp++; if (busy !== 1'b0) begin err++; $display("FAIL busy start queued: busy=%b want 0", busy); end
  endtask
  task automatic test_back_to_back;
    int lat, bc;
    @(negedge clk);
    op_a = 32'h40C00000;
    op_b = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bc);
    cmp++; if (done !== 1'b1 || result !== 32'h40400000) begin err++; $display("FAIL b2b first: done=%b result=%h want 1 40400000", done, result); end
    op_a = 32'h3F800000;
    op_b = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bc);
    cmp++; if (result !== THIRD || lat !== 29) begin err++; $display("FAIL b2b second: got %h lat %0d want %h lat 29", result, lat, THIRD); end
  endtask
  task automatic test_async_reset;
    logic [31:0] r;
    logic [4:0] f;
    int lat, bc;
    @(negedge clk);
    op_a = 32'h40C00000;
    op_b = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    cmp++; if ({busy, done, result, flg} !== 39'd0) begin err++; $display("FAIL async reset: busy=%b done=%b result=%h flags=%b want zero", busy, done, result, flg); end
    @(negedge clk);
    rst = 1'b0;
    do_op(32'h40C00000, 32'h40000000, r, f, lat, bc);
    cmp++; if (r !== 32'h40400000 || lat !== 29) begin err++; $display("FAIL after reset: got %h lat %0d want 40400000 lat 29", r, lat); end
  endtask
  initial begin
    cmp = 0;
    err = 0;
    rst = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op_a = '0;
    op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_divide();
    test_special();
    test_range();
    test_flush();
    test_busy_start();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
